ace_fetch_pktq: RTL and testbench

Parametrised fetch-packet queue between fetch stage 1 and the decode stage-0 instruction buffer. It replaces the fixed 8-wide f1->d0 register with a DEPTH-entry FIFO of FETCH_W-wide packets and a valid/ready handshake. Each packet's slot mask is trimmed after a predicted-taken branch. Packets with no surviving valid slot are dropped instead of enqueued. Retire flush empties the queue in one cycle.

---
 rtl/ace_fetch_pktq.sv | 185 ++++++++++++++++++
 tb/tb_ace_fetch_pktq.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_fetch_pktq.sv
`default_nettype none
// ============================================================================
//  Module      : ace_fetch_pktq
//  Description : Fetch-packet queue between fetch stage 1 and the decode
//                stage-0 instruction buffer. DEPTH-entry FIFO of FETCH_W-wide
//                packets with valid/ready handshakes on both sides. Slot masks
//                are trimmed after a predicted-taken branch. Packets whose
//                trimmed mask is empty are dropped. Retire flush empties the
//                queue in one cycle.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: ACE_FETCHQ_BYPASS_EN
//    When defined, a packet arriving at an empty queue with decode ready is
//    forwarded combinationally to dec_* and is not stored.
// ----------------------------------------------------------------------------
//  Ports
//    clock          in   single clock, rising edge
//    reset_n        in   synchronous active-low reset
//    flush_i        in   retire flush, empties the queue
//    pkt_vld_i      in   fetch offers a packet
//    pkt_rdy_o      out  queue accepts a packet this cycle
//    pkt_pc_i       in   PC of slot 0
//    pkt_inst_i     in   slot k at [k*INST_W +: INST_W]
//    pkt_mask_i     in   per-slot valid from fetch
//    pkt_brtaken_i  in   predicted-taken branch in packet
//    pkt_brpos_i    in   slot of that branch
//    dec_vld_o      out  head packet valid
//    dec_rdy_i      in   decode consumes head packet
//    dec_pc_o       out  head PC
//    dec_inst_o     out  head instructions
//    dec_mask_o     out  head effective slot mask
//    count_o        out  occupancy
//    full_o         out  queue full
//    empty_o        out  queue empty
// ============================================================================
module ace_fetch_pktq #(
    parameter int FETCH_W = 8,
    parameter int DEPTH   = 4,
    parameter int PC_W    = 64,
    parameter int INST_W  = 32,
    parameter int BP_W    = $clog2(FETCH_W),
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush_i,
    input  logic                       pkt_vld_i,
    output logic                       pkt_rdy_o,
    input  logic [PC_W-1:0]            pkt_pc_i,
    input  logic [FETCH_W*INST_W-1:0]  pkt_inst_i,
    input  logic [FETCH_W-1:0]         pkt_mask_i,
    input  logic                       pkt_brtaken_i,
    input  logic [BP_W-1:0]            pkt_brpos_i,
    output logic                       dec_vld_o,
    input  logic                       dec_rdy_i,
    output logic [PC_W-1:0]            dec_pc_o,
    output logic [FETCH_W*INST_W-1:0]  dec_inst_o,
    output logic [FETCH_W-1:0]         dec_mask_o,
    output logic [CNT_W-1:0]           count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int PKT_W = FETCH_W * INST_W;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [PC_W-1:0]    pc_q   [DEPTH];
    logic [PC_W-1:0]    pc_d   [DEPTH];
    logic [PKT_W-1:0]   inst_q [DEPTH];
    logic [PKT_W-1:0]   inst_d [DEPTH];
    logic [FETCH_W-1:0] mask_q [DEPTH];
    logic [FETCH_W-1:0] mask_d [DEPTH];

    logic [IDX_W-1:0]   w_wr_idx;
    logic [IDX_W-1:0]   w_rd_idx;
    logic               w_empty;
    logic               w_full;
    logic [FETCH_W-1:0] w_br_keep;
    logic [FETCH_W-1:0] w_eff;
    logic               w_eff_nz;
    logic               w_bypass;
    logic               w_push;
    logic               w_pop;

    assign w_wr_idx = wr_ptr_q[IDX_W-1:0];
    assign w_rd_idx = rd_ptr_q[IDX_W-1:0];
    assign w_empty  = (wr_ptr_q == rd_ptr_q);
    assign w_full   = (w_wr_idx == w_rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

    // Slots after a predicted-taken branch are never executed; keep 0..brpos.
    always_comb begin
        w_br_keep = '1;
        for (int k = 0; k < FETCH_W; k++) begin
            w_br_keep[k] = ~pkt_brtaken_i | (BP_W'(k) <= pkt_brpos_i);
        end
    end

    assign w_eff    = pkt_mask_i & w_br_keep;
    assign w_eff_nz = |w_eff;

    // Ready looks only at local state: no decode-to-fetch combinational path.
    assign pkt_rdy_o = reset_n & ~w_full;

`ifdef ACE_FETCHQ_BYPASS_EN
    assign w_bypass   = reset_n & w_empty & pkt_vld_i & w_eff_nz & dec_rdy_i & ~flush_i;
    assign dec_vld_o  = ~w_empty | w_bypass;
    assign dec_pc_o   = w_bypass ? pkt_pc_i   : pc_q[w_rd_idx];
    assign dec_inst_o = w_bypass ? pkt_inst_i : inst_q[w_rd_idx];
    assign dec_mask_o = w_bypass ? w_eff      : mask_q[w_rd_idx];
`else
    assign w_bypass   = 1'b0;
    assign dec_vld_o  = ~w_empty;
    assign dec_pc_o   = pc_q[w_rd_idx];
    assign dec_inst_o = inst_q[w_rd_idx];
    assign dec_mask_o = mask_q[w_rd_idx];
`endif

    // A bypassed packet is consumed by decode directly and never stored.
    assign w_push = pkt_vld_i & pkt_rdy_o & ~flush_i & w_eff_nz & ~w_bypass;
    assign w_pop  = ~w_empty & dec_rdy_i & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        mask_d   = mask_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            for (int i = 0; i < DEPTH; i++) begin
                mask_d[i] = '0;
            end
        end else begin
            if (w_push) begin
                pc_d[w_wr_idx]   = pkt_pc_i;
                inst_d[w_wr_idx] = pkt_inst_i;
                mask_d[w_wr_idx] = w_eff;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (w_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_q[i]   <= '0;
                inst_q[i] <= '0;
                mask_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            mask_q   <= mask_d;
        end
    end

    assign count_o = count_q;
    assign full_o  = w_full;
    assign empty_o = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_ace_fetch_pktq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ace_fetch_pktq
//  Description : Self-checking bench for ace_fetch_pktq with a queue-based
//                reference model. Honours ACE_FETCHQ_BYPASS_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ace_fetch_pktq;

    localparam int FETCH_W = 8;
    localparam int DEPTH   = 4;
    localparam int PC_W    = 64;
    localparam int INST_W  = 32;
    localparam int BP_W    = 3;
    localparam int CNT_W   = 3;

    logic                      clock = 1'b0;
    logic                      reset_n;
    logic                      flush_i;
    logic                      pkt_vld_i;
    logic                      pkt_rdy_o;
    logic [PC_W-1:0]           pkt_pc_i;
    logic [FETCH_W*INST_W-1:0] pkt_inst_i;
    logic [FETCH_W-1:0]        pkt_mask_i;
    logic                      pkt_brtaken_i;
    logic [BP_W-1:0]           pkt_brpos_i;
    logic                      dec_vld_o;
    logic                      dec_rdy_i;
    logic [PC_W-1:0]           dec_pc_o;
    logic [FETCH_W*INST_W-1:0] dec_inst_o;
    logic [FETCH_W-1:0]        dec_mask_o;
    logic [CNT_W-1:0]          count_o;
    logic                      full_o;
    logic                      empty_o;

    always #5 clock = ~clock;

    ace_fetch_pktq #(
        .FETCH_W(FETCH_W), .DEPTH(DEPTH), .PC_W(PC_W), .INST_W(INST_W),
        .BP_W(BP_W), .CNT_W(CNT_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .flush_i(flush_i),
        .pkt_vld_i(pkt_vld_i), .pkt_rdy_o(pkt_rdy_o), .pkt_pc_i(pkt_pc_i),
        .pkt_inst_i(pkt_inst_i), .pkt_mask_i(pkt_mask_i),
        .pkt_brtaken_i(pkt_brtaken_i), .pkt_brpos_i(pkt_brpos_i),
        .dec_vld_o(dec_vld_o), .dec_rdy_i(dec_rdy_i), .dec_pc_o(dec_pc_o),
        .dec_inst_o(dec_inst_o), .dec_mask_o(dec_mask_o), .count_o(count_o),
        .full_o(full_o), .empty_o(empty_o)
    );

    typedef struct {
        logic [PC_W-1:0]           pc;
        logic [FETCH_W*INST_W-1:0] inst;
        logic [FETCH_W-1:0]        mask;
    } pkt_t;

    pkt_t mq[$];
    int   checks   = 0;
    int   failures = 0;

    // Slots 0..pos survive a taken branch: mask & (2^(pos+1) - 1).
    function automatic logic [FETCH_W-1:0] eff_of(input logic [FETCH_W-1:0] m,
                                                  input logic t, input logic [BP_W-1:0] pos);
        int p;
        p = int'(pos);
        if (t) return m & FETCH_W'((1 << (p + 1)) - 1);
        return m;
    endfunction

    function automatic bit model_bypass();
`ifdef ACE_FETCHQ_BYPASS_EN
        return (mq.size() == 0) && reset_n && pkt_vld_i && dec_rdy_i && !flush_i &&
               (eff_of(pkt_mask_i, pkt_brtaken_i, pkt_brpos_i) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Advance one clock, applying the queue rules to the model.
    task automatic tick();
        bit   acc, pop;
        pkt_t p;
        acc = reset_n && pkt_vld_i && (mq.size() < DEPTH) && !flush_i && !model_bypass() &&
              (eff_of(pkt_mask_i, pkt_brtaken_i, pkt_brpos_i) != 0);
        pop = reset_n && (mq.size() > 0) && dec_rdy_i && !flush_i;
        p.pc   = pkt_pc_i;
        p.inst = pkt_inst_i;
        p.mask = eff_of(pkt_mask_i, pkt_brtaken_i, pkt_brpos_i);
        @(posedge clock);
        if (!reset_n || flush_i) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(p);
        end
        #1;
    endtask

    task automatic set_pkt(input logic [PC_W-1:0] pc, input logic [FETCH_W-1:0] m,
                           input logic t, input logic [BP_W-1:0] pos);
        pkt_vld_i     = 1'b1;
        pkt_pc_i      = pc;
        pkt_inst_i    = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
        pkt_mask_i    = m;
        pkt_brtaken_i = t;
        pkt_brpos_i   = pos;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; flush_i = 1'b0; pkt_vld_i = 1'b0; dec_rdy_i = 1'b0;
        pkt_pc_i = '0; pkt_inst_i = '0; pkt_mask_i = '0;
        pkt_brtaken_i = 1'b0; pkt_brpos_i = '0;
        tick(); tick();
        checks++; if (pkt_rdy_o !== 1'b0) begin failures++; $display("FAIL reset_rdy_low got=%b exp=0", pkt_rdy_o); end
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count_o); end
        checks++; if ({dec_vld_o, empty_o, full_o} !== 3'b010) begin failures++; $display("FAIL reset_flags vld/empty/full got=%b exp=010", {dec_vld_o, empty_o, full_o}); end
        checks++; if ({dec_pc_o, dec_inst_o, dec_mask_o} !== '0) begin failures++; $display("FAIL reset_dec_data got pc=%h mask=%h exp=0", dec_pc_o, dec_mask_o); end
        reset_n = 1'b1;
        #1;
        checks++; if (pkt_rdy_o !== 1'b1) begin failures++; $display("FAIL reset_rdy_high got=%b exp=1", pkt_rdy_o); end
    endtask

    task automatic test_fill_backpressure();
        int n;
        n = 0;
        dec_rdy_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            set_pkt(64'h1000 + 64'(n) * 64'h20, 8'hFF, 1'b0, '0);
            #1;
            if (!pkt_rdy_o) break;
            tick();
            n++;
        end
        checks++; if (n !== 4) begin failures++; $display("FAIL fill_accepted got=%0d exp=4", n); end
        tick(); #1;
        checks++; if (count_o !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d exp=4", count_o); end
        checks++; if ({full_o, pkt_rdy_o} !== 2'b10) begin failures++; $display("FAIL fill_full_rdy got=%b exp=10", {full_o, pkt_rdy_o}); end
        pkt_vld_i = 1'b0;
        dec_rdy_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dec_vld_o !== 1'b1 || dec_pc_o !== 64'h1000 + 64'(i) * 64'h20) begin
                failures++; $display("FAIL drain_pc[%0d] got vld=%b pc=%h exp pc=%h", i, dec_vld_o, dec_pc_o, 64'h1000 + 64'(i) * 64'h20);
            end
            if (i == 1) begin
                checks++; if (pkt_rdy_o !== 1'b1) begin failures++; $display("FAIL rdy_after_pop got=%b exp=1", pkt_rdy_o); end
            end
            tick();
        end
        #1;
        checks++; if (empty_o !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", empty_o); end
        dec_rdy_i = 1'b0;
    endtask

    task automatic test_branch_trim();
        dec_rdy_i = 1'b0;
        set_pkt(64'h3000, 8'hFF, 1'b1, 3'd3);
        #1; tick();
        pkt_vld_i = 1'b0;
        #1;
        checks++; if (dec_vld_o !== 1'b1 || dec_mask_o !== 8'h0F) begin failures++; $display("FAIL trim_mask got vld=%b mask=%h exp mask=0f", dec_vld_o, dec_mask_o); end
        set_pkt(64'h3020, 8'hF0, 1'b1, 3'd2);
        #1;
        checks++; if (pkt_rdy_o !== 1'b1) begin failures++; $display("FAIL drop_rdy got=%b exp=1", pkt_rdy_o); end
        tick();
        pkt_vld_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd1 || dec_pc_o !== 64'h3000) begin failures++; $display("FAIL drop_count got cnt=%0d pc=%h exp cnt=1 pc=3000", count_o, dec_pc_o); end
        dec_rdy_i = 1'b1;
        tick();
        dec_rdy_i = 1'b0;
    endtask

    task automatic test_simul_pushpop();
        dec_rdy_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            set_pkt(64'h4000 + 64'(i) * 64'h20, 8'hFF, 1'b0, '0);
            #1; tick();
        end
        dec_rdy_i = 1'b1;
        for (int k = 0; k < 3 * DEPTH; k++) begin
            set_pkt(64'h4040 + 64'(k) * 64'h20, 8'hFF, 1'b0, '0);
            #1;
            checks++;
            if (count_o !== 3'd2 || dec_pc_o !== 64'h4000 + 64'(k) * 64'h20) begin
                failures++; $display("FAIL pushpop[%0d] got cnt=%0d pc=%h exp cnt=2 pc=%h", k, count_o, dec_pc_o, 64'h4000 + 64'(k) * 64'h20);
            end
            tick();
        end
        pkt_vld_i = 1'b0;
        tick(); tick();
        dec_rdy_i = 1'b0;
    endtask

    task automatic test_flush();
        dec_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pkt(64'h6000 + 64'(i) * 64'h20, 8'hFF, 1'b0, '0);
            #1; tick();
        end
        set_pkt(64'h6060, 8'hFF, 1'b0, '0);
        dec_rdy_i = 1'b1;
        flush_i   = 1'b1;
        #1; tick();
        flush_i   = 1'b0;
        dec_rdy_i = 1'b0;
        set_pkt(64'h2000, 8'hFF, 1'b0, '0);
        #1;
        checks++; if (count_o !== 3'd0 || dec_vld_o !== 1'b0 || pkt_rdy_o !== 1'b1) begin failures++; $display("FAIL flush_empty got cnt=%0d vld=%b rdy=%b exp 0 0 1", count_o, dec_vld_o, pkt_rdy_o); end
        tick();
        pkt_vld_i = 1'b0;
        #1;
        checks++; if (dec_vld_o !== 1'b1 || dec_pc_o !== 64'h2000 || count_o !== 3'd1) begin failures++; $display("FAIL flush_repush got vld=%b pc=%h cnt=%0d exp 1 2000 1", dec_vld_o, dec_pc_o, count_o); end
        dec_rdy_i = 1'b1;
        tick();
        dec_rdy_i = 1'b0;
    endtask

    task automatic test_bypass();
        dec_rdy_i = 1'b1;
        set_pkt(64'h5000, 8'hFF, 1'b0, '0);
        #1;
`ifdef ACE_FETCHQ_BYPASS_EN
        checks++; if (dec_vld_o !== 1'b1 || dec_pc_o !== 64'h5000 || count_o !== 3'd0) begin failures++; $display("FAIL bypass_same got vld=%b pc=%h cnt=%0d exp 1 5000 0", dec_vld_o, dec_pc_o, count_o); end
        tick();
        pkt_vld_i = 1'b0;
        #1;
        checks++; if (count_o !== 3'd0 || dec_vld_o !== 1'b0) begin failures++; $display("FAIL bypass_after got cnt=%0d vld=%b exp 0 0", count_o, dec_vld_o); end
`else
        checks++; if (dec_vld_o !== 1'b0) begin failures++; $display("FAIL nobypass_same got vld=%b exp=0", dec_vld_o); end
        tick();
        pkt_vld_i = 1'b0;
        #1;
        checks++; if (dec_vld_o !== 1'b1 || dec_pc_o !== 64'h5000 || count_o !== 3'd1) begin failures++; $display("FAIL nobypass_next got vld=%b pc=%h cnt=%0d exp 1 5000 1", dec_vld_o, dec_pc_o, count_o); end
        tick();
        #1;
        checks++; if (count_o !== 3'd0) begin failures++; $display("FAIL nobypass_drain got cnt=%0d exp=0", count_o); end
`endif
        dec_rdy_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        dec_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_pkt(64'($urandom), 8'hFF, 1'b0, '0);
            #1; tick();
        end
        #1;
        checks++; if (count_o !== 3'd3) begin failures++; $display("FAIL mid_prefill got cnt=%0d exp=3", count_o); end
        reset_n = 1'b0;
        #1;
        checks++; if (pkt_rdy_o !== 1'b0) begin failures++; $display("FAIL mid_rdy_low got=%b exp=0", pkt_rdy_o); end
        tick();
        checks++; if (count_o !== 3'd0 || dec_vld_o !== 1'b0 || dec_mask_o !== 8'h00 || dec_pc_o !== '0 || empty_o !== 1'b1 || full_o !== 1'b0) begin
            failures++; $display("FAIL mid_reset_state got cnt=%0d vld=%b mask=%h pc=%h empty=%b full=%b", count_o, dec_vld_o, dec_mask_o, dec_pc_o, empty_o, full_o);
        end
        reset_n   = 1'b1;
        pkt_vld_i = 1'b0;
        #1;
        checks++; if (pkt_rdy_o !== 1'b1 || count_o !== 3'd0) begin failures++; $display("FAIL mid_after got rdy=%b cnt=%0d exp 1 0", pkt_rdy_o, count_o); end
    endtask

    task automatic test_random();
        logic [FETCH_W-1:0] e;
        bit                 byp;
        for (int c = 0; c < 400; c++) begin
            set_pkt({32'($urandom), 32'($urandom)},
                    ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom),
                    ($urandom_range(0, 9) < 3), 3'($urandom));
            pkt_vld_i = ($urandom_range(0, 9) < 7);
            dec_rdy_i = ($urandom_range(0, 9) < 5);
            flush_i   = ($urandom_range(0, 49) == 0);
            #1;
            byp = model_bypass();
            e   = eff_of(pkt_mask_i, pkt_brtaken_i, pkt_brpos_i);
            checks++;
            if (count_o !== CNT_W'(mq.size()) || empty_o !== (mq.size() == 0) ||
                full_o !== (mq.size() == DEPTH) || pkt_rdy_o !== (mq.size() < DEPTH)) begin
                failures++; $display("FAIL rnd_status[%0d] got cnt=%0d e=%b f=%b rdy=%b exp cnt=%0d", c, count_o, empty_o, full_o, pkt_rdy_o, mq.size());
            end
            checks++;
            if (dec_vld_o !== (byp || mq.size() > 0)) begin
                failures++; $display("FAIL rnd_vld[%0d] got=%b exp=%b", c, dec_vld_o, (byp || mq.size() > 0));
            end else if (byp) begin
                checks++;
                if (dec_pc_o !== pkt_pc_i || dec_inst_o !== pkt_inst_i || dec_mask_o !== e) begin
                    failures++; $display("FAIL rnd_bypass[%0d] got pc=%h mask=%h exp pc=%h mask=%h", c, dec_pc_o, dec_mask_o, pkt_pc_i, e);
                end
            end else if (mq.size() > 0) begin
                checks++;
                if (dec_pc_o !== mq[0].pc || dec_inst_o !== mq[0].inst || dec_mask_o !== mq[0].mask) begin
                    failures++; $display("FAIL rnd_head[%0d] got pc=%h mask=%h exp pc=%h mask=%h", c, dec_pc_o, dec_mask_o, mq[0].pc, mq[0].mask);
                end
            end
            tick();
        end
        flush_i   = 1'b0;
        pkt_vld_i = 1'b0;
        dec_rdy_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fill_backpressure();
        test_branch_trim();
        test_simul_pushpop();
        test_flush();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
